// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared constants for the highway/country-road phase
//                scheduler: lamp encodings, phase state codes and the dwell
//                counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

   // Dwell counter width and its saturation value
   localparam int               c_CNT_W   = 5;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = 5'd31;

   // Lamp encodings
   localparam logic [1:0] c_LIGHT_R = 2'b00;
   localparam logic [1:0] c_LIGHT_Y = 2'b01;
   localparam logic [1:0] c_LIGHT_G = 2'b10;

   // Phase state codes (also driven on the debug phase output)
   localparam logic [2:0] c_ST_HG  = 3'd0;   // highway green
   localparam logic [2:0] c_ST_HY  = 3'd1;   // highway yellow
   localparam logic [2:0] c_ST_AR1 = 3'd2;   // all red, towards country
   localparam logic [2:0] c_ST_CG  = 3'd3;   // country green
   localparam logic [2:0] c_ST_CY  = 3'd4;   // country yellow
   localparam logic [2:0] c_ST_AR2 = 3'd5;   // all red, towards highway

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Per-phase dwell counter. Restarts from 0 on phase entry,
//                counts one per cycle and saturates at the maximum count.
//                Flags the terminal cycle of an N-cycle dwell (count==N-1).
//  Ports       : clock     - rising-edge clock
//                clear_n   - synchronous active-low reset
//                restart   - phase changes on this edge; next count is 0
//                dwell_len - dwell length N in cycles (1..31)
//                count     - current dwell count
//                done      - high on the last cycle of the N-cycle dwell
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
   import traffic_pkg::*;
(
   input  logic               clock,
   input  logic               clear_n,
   input  logic               restart,
   input  logic [c_CNT_W-1:0] dwell_len,
   output logic [c_CNT_W-1:0] count,
   output logic               done
);

   logic [c_CNT_W-1:0] r_count;

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_count <= '0;
      end else if (restart) begin
         r_count <= '0;
      end else if (r_count != c_CNT_MAX) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;
   assign done  = (r_count == (dwell_len - 1'b1));

endmodule : dwell_timer
`default_nettype wire

// File: rtl/traffic_phase_sched.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_sched
//  Description : Moore-style highway/country-road traffic phase scheduler
//                with pedestrian walk and emergency preemption towards the
//                highway. Outputs decode from registered state only.
//  Ports       : clock      - rising-edge clock
//                clear_n    - synchronous active-low reset
//                car_x      - country-road car sensor (level)
//                ped_req    - pedestrian button (any high cycle = request)
//                emerg      - emergency preempt, favours the highway (level)
//                hwy_light  - highway lamp  (R=00, Y=01, G=10)
//                ctry_light - country lamp  (R=00, Y=01, G=10)
//                ped_walk   - walk indication for the country crossing
//                phase      - current phase code, debug only
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int Y2R_CYCLES     = 3,
   parameter int R2G_CYCLES     = 2,
   parameter int MIN_GREEN      = 8,
   parameter int MAX_CTRY_GREEN = 16
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       car_x,
   input  logic       ped_req,
   input  logic       emerg,
   output logic [1:0] hwy_light,
   output logic [1:0] ctry_light,
   output logic       ped_walk,
   output logic [2:0] phase
);

   localparam logic [c_CNT_W-1:0] c_Y2R      = c_CNT_W'(Y2R_CYCLES);
   localparam logic [c_CNT_W-1:0] c_R2G      = c_CNT_W'(R2G_CYCLES);
   localparam logic [c_CNT_W-1:0] c_MIN_LAST = c_CNT_W'(MIN_GREEN - 1);
   localparam logic [c_CNT_W-1:0] c_MAX_CG   = c_CNT_W'(MAX_CTRY_GREEN);

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic               r_req_pend;
   logic               r_ped_pend;
   logic               r_walk_latch;
   logic [c_CNT_W-1:0] w_count;
   logic [c_CNT_W-1:0] w_dwell_len;
   logic               w_done;
   logic               w_min_met;
   logic               w_restart;
   logic               w_enter_cg;
   logic               w_exit_cg;
   logic               w_ped_pend_nxt;

   // ------------------------------------------------------------------
   // Dwell timer
   // ------------------------------------------------------------------
   assign w_restart = (w_state_nxt != r_state);
   assign w_min_met = (w_count >= c_MIN_LAST);

   always_comb begin
      w_dwell_len = c_MAX_CG;
      case (r_state)
         c_ST_HY, c_ST_CY:   w_dwell_len = c_Y2R;
         c_ST_AR1, c_ST_AR2: w_dwell_len = c_R2G;
         default:            w_dwell_len = c_MAX_CG;
      endcase
   end

   dwell_timer u_dwell_timer (
      .clock     (clock),
      .clear_n   (clear_n),
      .restart   (w_restart),
      .dwell_len (w_dwell_len),
      .count     (w_count),
      .done      (w_done)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_state <= c_ST_HG;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_HG:  if (w_min_met && r_req_pend && !emerg) w_state_nxt = c_ST_HY;
         c_ST_HY:  if (w_done) w_state_nxt = c_ST_AR1;
         c_ST_AR1: if (w_done) w_state_nxt = c_ST_CG;
         // Country green ends early on emergency, once demand is gone
         // after the minimum green, or at the hard cap.
         c_ST_CG:  if (emerg || (!car_x && w_min_met) || w_done)
                      w_state_nxt = c_ST_CY;
         c_ST_CY:  if (w_done) w_state_nxt = c_ST_AR2;
         c_ST_AR2: if (w_done) w_state_nxt = c_ST_HG;
         default:  w_state_nxt = c_ST_HG;
      endcase
   end

   // ------------------------------------------------------------------
   // Request and pedestrian flags
   // ------------------------------------------------------------------
   assign w_enter_cg = (w_state_nxt == c_ST_CG) && (r_state != c_ST_CG);
   assign w_exit_cg  = (r_state == c_ST_CG) && (w_state_nxt != c_ST_CG);

   // Button presses during country green are not latched, so they cannot
   // extend or re-trigger the walk already being served.
   assign w_ped_pend_nxt = (ped_req && (r_state != c_ST_CG)) ? 1'b1 :
                           (w_exit_cg ? 1'b0 : r_ped_pend);

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_req_pend   <= 1'b0;
         r_ped_pend   <= 1'b0;
         r_walk_latch <= 1'b0;
      end else begin
         // A new request in the entry cycle outranks the clear
         if (car_x || ped_req) begin
            r_req_pend <= 1'b1;
         end else if (w_enter_cg) begin
            r_req_pend <= 1'b0;
         end
         r_ped_pend <= w_ped_pend_nxt;
         // Walk decision is frozen for the whole country green
         if (w_enter_cg) begin
            r_walk_latch <= w_ped_pend_nxt;
         end else if (w_exit_cg) begin
            r_walk_latch <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output decode (registered state only)
   // ------------------------------------------------------------------
   always_comb begin
      hwy_light  = c_LIGHT_R;
      ctry_light = c_LIGHT_R;
      case (r_state)
         c_ST_HG: hwy_light  = c_LIGHT_G;
         c_ST_HY: hwy_light  = c_LIGHT_Y;
         c_ST_CG: ctry_light = c_LIGHT_G;
         c_ST_CY: ctry_light = c_LIGHT_Y;
         default: begin
            hwy_light  = c_LIGHT_R;
            ctry_light = c_LIGHT_R;
         end
      endcase
      ped_walk = (r_state == c_ST_CG) && r_walk_latch;
      phase    = r_state;
   end

endmodule : traffic_phase_sched
`default_nettype wire

// File: tb/tb_traffic_phase_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_sched
//  Description : Self-checking bench for traffic_phase_sched. Directed
//                scenarios followed by randomized traffic; expected outputs
//                come from a behavioural reference model and are queued for
//                a separate monitor to compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sched;

   localparam int Y2R  = 3;
   localparam int R2G  = 2;
   localparam int MING = 8;
   localparam int MAXC = 16;

   logic       clock;
   logic       clear_n;
   logic       car_x;
   logic       ped_req;
   logic       emerg;
   logic [1:0] hwy_light;
   logic [1:0] ctry_light;
   logic       ped_walk;
   logic [2:0] phase;

   int errors = 0;
   int checks = 0;

   traffic_phase_sched #(
      .Y2R_CYCLES     (Y2R),
      .R2G_CYCLES     (R2G),
      .MIN_GREEN      (MING),
      .MAX_CTRY_GREEN (MAXC)
   ) dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .car_x      (car_x),
      .ped_req    (ped_req),
      .emerg      (emerg),
      .hwy_light  (hwy_light),
      .ctry_light (ctry_light),
      .ped_walk   (ped_walk),
      .phase      (phase)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ------------------------------------------------------------------
   // Reference model: phase index in road order, cycles already served
   // in that phase, and the request bookkeeping.
   // ------------------------------------------------------------------
   int m_ph     = 0;
   int m_served = 0;
   bit m_req    = 0;
   bit m_ped    = 0;
   bit m_walk   = 0;
   bit m_known  = 0;

   logic [7:0] sb[$];   // {phase, hwy, ctry, walk}

   function automatic logic [7:0] model_out();
      logic [1:0] h;
      logic [1:0] c;
      h = (m_ph == 0) ? 2'b10 : (m_ph == 1) ? 2'b01 : 2'b00;
      c = (m_ph == 3) ? 2'b10 : (m_ph == 4) ? 2'b01 : 2'b00;
      return {m_ph[2:0], h, c, (m_ph == 3) && m_walk};
   endfunction

   task automatic model_step(input bit c, input bit p, input bit e, input bit rn);
      int  done_cnt;
      bit  leave;
      int  nph;
      bit  nped;
      if (!rn) begin
         m_ph = 0; m_served = 0; m_req = 0; m_ped = 0; m_walk = 0;
         m_known = 1;
         return;
      end
      done_cnt = m_served + 1;   // cycles in phase including this one
      case (m_ph)
         0:       leave = (done_cnt >= MING) && m_req && !e;
         1, 4:    leave = (done_cnt == Y2R);
         2, 5:    leave = (done_cnt == R2G);
         default: leave = e || (!c && done_cnt >= MING) || (done_cnt == MAXC);
      endcase
      nph  = leave ? (m_ph + 1) % 6 : m_ph;
      nped = m_ped;
      if (m_ph != 3 && p) nped = 1;
      if (m_ph == 3 && leave) nped = 0;
      if (nph == 3 && m_ph != 3) m_walk = nped;
      else if (m_ph == 3 && leave) m_walk = 0;
      if (c || p) m_req = 1;
      else if (nph == 3 && m_ph != 3) m_req = 0;
      m_ped    = nped;
      m_served = leave ? 0 : m_served + 1;
      m_ph     = nph;
   endtask

   // One clock cycle of stimulus: drive, queue the expectation for the
   // cycle now running, then advance the model across the edge.
   task automatic cycle(input bit c, input bit p, input bit e, input bit rn);
      car_x   = c;
      ped_req = p;
      emerg   = e;
      clear_n = rn;
      if (m_known) sb.push_back(model_out());
      @(posedge clock);
      model_step(c, p, e, rn);
      #2;
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b1, 1'b0, 1'b0);   // inputs during reset must be ignored
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // ------------------------------------------------------------------
   // Monitor: compares every cycle the DUT presents outputs
   // ------------------------------------------------------------------
   initial begin : monitor
      logic [7:0] exp;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({phase, hwy_light, ctry_light, ped_walk} !== exp) begin
               errors++;
               $display("FAIL outputs t=%0t: got phase=%0d hwy=%b ctry=%b walk=%b, expected phase=%0d hwy=%b ctry=%b walk=%b",
                        $time, phase, hwy_light, ctry_light, ped_walk,
                        exp[7:5], exp[4:3], exp[2:1], exp[0]);
            end
            checks++;
            if (hwy_light !== 2'b00 && ctry_light !== 2'b00) begin
               errors++;
               $display("FAIL lamp_conflict t=%0t: got hwy=%b ctry=%b, expected at least one R",
                        $time, hwy_light, ctry_light);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin : stim
      bit rc, rp, re, rr;
      car_x = 0; ped_req = 0; emerg = 0; clear_n = 0;

      // Reset, then idle: highway green must hold
      do_reset();
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);

      // Car held: full sequence with capped country green
      do_reset();
      for (int i = 0; i < 45; i++) cycle(1, 0, 0, 1);

      // Single-cycle car pulse: country green ends at minimum
      do_reset();
      cycle(1, 0, 0, 1);
      for (int i = 0; i < 30; i++) cycle(0, 0, 0, 1);

      // Pedestrian at HG cycle 2, second press during country green
      do_reset();
      for (int i = 0; i < 40; i++) cycle(0, (i == 2) || (i == 16), 0, 1);

      // Emergency at country-green cycle 4, held with car present
      do_reset();
      for (int i = 0; i < 45; i++) cycle(1, 0, (i >= 17), 1);

      // Reset in the middle of country green
      do_reset();
      for (int i = 0; i < 30; i++) cycle(1, 0, 0, (i != 18));

      // Randomized traffic
      do_reset();
      rc = 0; re = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)  rc = ~rc;
         if ($urandom_range(0, 40) == 0) re = ~re;
         rp = ($urandom_range(0, 29) == 0);
         rr = ($urandom_range(0, 299) != 0);
         cycle(rc, rp, re, rr);
      end

      @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_traffic_phase_sched
`default_nettype wire
